// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-sequencing controller:
// opcode and state encodings, ALU select codes and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    NOOP  = 4'd0,
    STORE = 4'd1,
    LOAD  = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    NOOP_S  = 4'd3,
    STORE_S = 4'd4,
    LOAD_A  = 4'd5,
    LOAD_B  = 4'd6,
    ADD_S   = 4'd7,
    SUB_S   = 4'd8,
    HALT_S  = 4'd9
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Instruction field bit positions
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RA_HI    = 11;   // first source register (STORE/ADD/SUB)
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;    // second source register (ADD/SUB)
  localparam int RB_LO    = 4;
  localparam int RW_HI    = 3;    // destination register (LOAD/ADD/SUB)
  localparam int RW_LO    = 0;
  localparam int SADDR_HI = 7;    // STORE data address
  localparam int SADDR_LO = 0;
  localparam int LADDR_HI = 11;   // LOAD data address
  localparam int LADDR_LO = 4;

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear, increment on request, natural wrap.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            up,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_reg;

  // Clear has priority; the counter wraps from all-ones to zero on its own.
  always_ff @(posedge clk) begin
    if (clr)
      pc_reg <= '0;
    else if (up)
      pc_reg <= pc_reg + 1'b1;
  end

  assign pc = pc_reg;

endmodule

// File: rtl/control_unit.sv
// Moore controller: fetches 16-bit instructions from a 1-cycle-latency ROM,
// holds PC and IR, and drives every datapath control input from state and IR.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     I_data,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     IR,
  output logic [3:0]      state,
  output logic            halted,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0
);

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic        pc_clr;
  logic        pc_up;

  // PC only advances while fetching; reset clears it on the same edge as the FSM.
  assign pc_clr = ~rst_n;
  assign pc_up  = (state_reg == FETCH);

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk (clk),
    .clr (pc_clr),
    .up  (pc_up),
    .pc  (PC)
  );

  // Sequencing FSM and instruction register; HALT holds until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= INIT;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        INIT:   state_reg <= FETCH;
        FETCH: begin
          ir_reg    <= I_data;
          state_reg <= DECODE;
        end
        DECODE: begin
          case (ir_reg[OPC_HI:OPC_LO])
            STORE:   state_reg <= STORE_S;
            LOAD:    state_reg <= LOAD_A;
            ADD:     state_reg <= ADD_S;
            SUB:     state_reg <= SUB_S;
            HALT:    state_reg <= HALT_S;
            default: state_reg <= NOOP_S;   // NOOP and all undefined opcodes
          endcase
        end
        LOAD_A:  state_reg <= LOAD_B;     // data memory read latency cycle
        HALT_S:  state_reg <= HALT_S;
        default: state_reg <= FETCH;      // NOOP_S, STORE_S, LOAD_B, ADD_S, SUB_S
      endcase
    end
  end

  assign IR    = ir_reg;
  assign state = state_reg;

  // Control outputs decoded from the registered state and IR; everything idles at 0.
  always_comb begin
    halted     = 1'b0;
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Alu_s0     = ALU_PASS;
    case (state_reg)
      STORE_S: begin
        RF_Ra_addr = ir_reg[RA_HI:RA_LO];
        D_Addr     = ir_reg[SADDR_HI:SADDR_LO];
        D_wr       = 1'b1;
      end
      LOAD_A, LOAD_B: begin
        D_Addr    = ir_reg[LADDR_HI:LADDR_LO];
        RF_s      = 1'b1;
        RF_W_addr = ir_reg[RW_HI:RW_LO];
        RF_W_en   = (state_reg == LOAD_B);
      end
      ADD_S, SUB_S: begin
        RF_Ra_addr = ir_reg[RA_HI:RA_LO];
        RF_Rb_addr = ir_reg[RB_HI:RB_LO];
        RF_W_addr  = ir_reg[RW_HI:RW_LO];
        RF_W_en    = 1'b1;
        Alu_s0     = (state_reg == ADD_S) ? ALU_ADD : ALU_SUB;
      end
      HALT_S:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed programs with literal
// expectations plus randomized programs checked every cycle against a
// sequence-table model of instruction execution.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] I_data;
  logic [6:0]  PC;
  logic [15:0] IR;
  logic [3:0]  state;
  logic        halted;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;

  control_unit #(.PC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .I_data(I_data), .PC(PC), .IR(IR),
    .state(state), .halted(halted), .D_Addr(D_Addr), .D_wr(D_wr),
    .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency instruction ROM
  logic [15:0] rom [128];
  always @(posedge clk) I_data <= rom[PC];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } ctl_t;

  // What the datapath controls must be for a given step of an instruction.
  function automatic ctl_t expect_ctl(input state_t s, input logic [15:0] ir);
    ctl_t c = '0;
    case (s)
      STORE_S: begin c.ra = ir[11:8]; c.d_addr = ir[7:0]; c.d_wr = 1'b1; end
      LOAD_A:  begin c.d_addr = ir[11:4]; c.rf_s = 1'b1; c.w_addr = ir[3:0]; end
      LOAD_B:  begin c.d_addr = ir[11:4]; c.rf_s = 1'b1; c.w_addr = ir[3:0]; c.w_en = 1'b1; end
      ADD_S:   begin c.ra = ir[11:8]; c.rb = ir[7:4]; c.w_addr = ir[3:0]; c.w_en = 1'b1; c.alu = 3'b001; end
      SUB_S:   begin c.ra = ir[11:8]; c.rb = ir[7:4]; c.w_addr = ir[3:0]; c.w_en = 1'b1; c.alu = 3'b010; end
      HALT_S:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Reference model: each fetched instruction expands into a fixed list of
  // execute steps taken from its opcode; the model walks that list.
  bit          m_valid = 1'b0;
  state_t      m_cur   = INIT;
  logic [6:0]  m_pc    = '0;
  logic [15:0] m_ir    = '0;
  state_t      m_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_cur   = INIT;
      m_pc    = '0;
      m_ir    = '0;
      m_q.delete();
    end else if (m_valid) begin
      if (m_cur == INIT) m_cur = FETCH;
      else if (m_cur == FETCH) begin
        m_ir = rom[m_pc];
        m_pc = m_pc + 7'd1;
        m_q.delete();
        case (m_ir[15:12])
          4'd1:    m_q = '{STORE_S};
          4'd2:    m_q = '{LOAD_A, LOAD_B};
          4'd3:    m_q = '{ADD_S};
          4'd4:    m_q = '{SUB_S};
          4'd5:    m_q = '{HALT_S};
          default: m_q = '{NOOP_S};
        endcase
        m_cur = DECODE;
      end else if (m_cur == HALT_S) m_cur = HALT_S;
      else if (m_q.size() > 0) m_cur = m_q.pop_front();
      else m_cur = FETCH;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      ctl_t act;
      act = '{D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0, halted};
      chk("model_state", 64'(state), 64'(m_cur));
      chk("model_pc", 64'(PC), 64'(m_pc));
      chk("model_ir", 64'(IR), 64'(m_ir));
      chk("model_ctl", 64'(act), 64'(expect_ctl(m_cur, m_ir)));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    step(cycles);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rst_n = 1'b0;
    step(3);

    // Reset state
    chk("rst_state", 64'(state), 64'(INIT));
    chk("rst_pc", 64'(PC), 64'd0);
    chk("rst_ir", 64'(IR), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // Directed program: LOAD, ADD, SUB, STORE, undefined, HALT
    rom[0] = 16'h21B2; rom[1] = 16'h3123; rom[2] = 16'h4123;
    rom[3] = 16'h122A; rom[4] = 16'hF123; rom[5] = 16'h5000;
    rst_n = 1'b1;
    step(1);
    $display("prog: FETCH pc=%0h", PC);
    chk("first_fetch", 64'(state), 64'(FETCH));
    chk("first_fetch_pc", 64'(PC), 64'd0);
    step(1);
    chk("decode_pc", 64'(PC), 64'd1);
    chk("decode_ir", 64'(IR), 64'h21B2);
    step(1);
    $display("LOAD_A: daddr=%0h rf_s=%0d waddr=%0d wen=%0d", D_Addr, RF_s, RF_W_addr, RF_W_en);
    chk("load_a_state", 64'(state), 64'(LOAD_A));
    chk("model_load_a", 64'(m_cur), 64'(LOAD_A));
    chk("load_a_daddr", 64'(D_Addr), 64'h1B);
    chk("load_a_rfs", 64'(RF_s), 64'd1);
    chk("load_a_waddr", 64'(RF_W_addr), 64'd2);
    chk("load_a_wen", 64'(RF_W_en), 64'd0);
    step(1);
    $display("LOAD_B: wen=%0d", RF_W_en);
    chk("load_b_wen", 64'(RF_W_en), 64'd1);
    chk("load_b_daddr", 64'(D_Addr), 64'h1B);
    step(1);
    chk("load_next_fetch", 64'(state), 64'(FETCH));
    chk("load_next_wen", 64'(RF_W_en), 64'd0);
    step(2);
    $display("ADD_S: ra=%0d rb=%0d wa=%0d alu=%0b wen=%0d", RF_Ra_addr, RF_Rb_addr, RF_W_addr, Alu_s0, RF_W_en);
    chk("add_state", 64'(state), 64'(ADD_S));
    chk("add_ctl", 64'({RF_Ra_addr, RF_Rb_addr, RF_W_addr, Alu_s0, RF_s, RF_W_en}),
        64'({4'd1, 4'd2, 4'd3, 3'b001, 1'b0, 1'b1}));
    step(1);
    chk("add_wen_1cycle", 64'(RF_W_en), 64'd0);
    step(2);
    $display("SUB_S: alu=%0b wen=%0d", Alu_s0, RF_W_en);
    chk("sub_ctl", 64'({RF_Ra_addr, RF_Rb_addr, RF_W_addr, Alu_s0, RF_s, RF_W_en}),
        64'({4'd1, 4'd2, 4'd3, 3'b010, 1'b0, 1'b1}));
    step(3);
    $display("STORE_S: ra=%0d daddr=%0h dwr=%0d", RF_Ra_addr, D_Addr, D_wr);
    chk("store_state", 64'(state), 64'(STORE_S));
    chk("store_ctl", 64'({RF_Ra_addr, D_Addr, D_wr, RF_W_en}), 64'({4'd2, 8'h2A, 1'b1, 1'b0}));
    step(1);
    chk("store_dwr_1cycle", 64'(D_wr), 64'd0);
    step(2);
    $display("undef: state=%0d ir=%0h", state, IR);
    chk("undef_state", 64'(state), 64'(NOOP_S));
    chk("undef_writes", 64'({D_wr, RF_W_en}), 64'd0);
    step(3);
    chk("halt_state", 64'(state), 64'(HALT_S));
    for (int i = 0; i < 20; i++) begin
      chk("halt_held", 64'({halted, D_wr, RF_W_en, PC, IR}), 64'({1'b1, 1'b0, 1'b0, 7'd6, 16'h5000}));
      step(1);
    end
    $display("HALT: halted=%0d pc=%0d", halted, PC);
    do_reset(1);
    chk("halt_reset", 64'({state, halted, PC}), 64'({4'(INIT), 1'b0, 7'd0}));
    step(1);

    // Reset mid-ADD, held two cycles
    for (int i = 0; i < 6; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3123;
    rst_n = 1'b1;
    step(3);
    chk("midadd_state", 64'(state), 64'(ADD_S));
    rst_n = 1'b0;
    step(1);
    $display("reset mid-ADD: state=%0d pc=%0d ir=%0h", state, PC, IR);
    chk("midadd_reset", 64'({state, PC, IR, D_wr, RF_W_en}), 64'({4'(INIT), 7'd0, 16'h0, 1'b0, 1'b0}));
    step(1);
    chk("midadd_hold", 64'(state), 64'(INIT));
    rst_n = 1'b1;
    step(1);
    chk("midadd_release", 64'(state), 64'(FETCH));

    // Reset landing on LOAD_A: no write enable ever
    do_reset(1);
    rom[0] = 16'h2345;
    rst_n = 1'b1;
    step(3);
    chk("midload_state", 64'(state), 64'(LOAD_A));
    rst_n = 1'b0;
    step(1);
    $display("reset mid-LOAD: state=%0d wen=%0d", state, RF_W_en);
    chk("midload_reset", 64'({state, RF_W_en}), 64'({4'(INIT), 1'b0}));

    // PC wrap: ROM of NOOPs, fetch address 127 then PC reads 0
    rom[0] = 16'h0000;
    rst_n = 1'b1;
    step(382);
    chk("wrap_fetch127", 64'({state, PC}), 64'({4'(FETCH), 7'd127}));
    step(1);
    $display("wrap: state=%0d pc=%0d", state, PC);
    chk("wrap_pc0", 64'({state, PC}), 64'({4'(DECODE), 7'd0}));

    // Randomized programs with occasional resets
    for (int r = 0; r < 6; r++) begin
      rst_n = 1'b0;
      for (int i = 0; i < 128; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd3;
        rom[i] = {op, 12'($urandom)};
      end
      step(1 + $urandom_range(0, 1));
      rst_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
        rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        step(1);
      end
      $display("random round %0d: pc=%0d state=%0d", r, PC, state);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-FSM controller that fetches 16-bit instructions from a synchronous instruction ROM and sequences the processor datapath (register file, ALU, result mux, data memory) one instruction at a time. It owns the program counter and instruction register. It drives every datapath control input: D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr and Alu_s0. It sits between the instruction ROM and the Datapath in the processor top level.

## Interface
Parameters:
- PC_W, 7, program counter / instruction ROM address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- I_data  input  16  instruction ROM read data; valid 1 cycle after PC changes.
- PC  output  PC_W  instruction ROM address (registered).
- IR  output  16  instruction register (registered).
- state  output  4  current FSM state encoding, for debug.
- halted  output  1  high while in HALT.
- D_Addr  output  8  data memory address.
- D_wr  output  1  data memory write enable.
- RF_s  output  1  write-back mux select: 0 = ALU, 1 = data memory.
- RF_W_addr  output  4  register file write address.
- RF_W_en  output  1  register file write enable.
- RF_Ra_addr, RF_Rb_addr  output  4 each  register file read addresses.
- Alu_s0  output  3  ALU operation select.

## Operation
Instruction fields:
- IR[15:12] is the opcode.
- NOOP 0000: no fields.
- STORE 0001: D[IR[7:0]] = R[IR[11:8]].
- LOAD 0010: R[IR[3:0]] = D[IR[11:4]].
- ADD 0011: R[IR[3:0]] = R[IR[11:8]] + R[IR[7:4]].
- SUB 0100: R[IR[3:0]] = R[IR[11:8]] - R[IR[7:4]].
- HALT 0101: stop.
- Opcodes 0110–1111 execute as NOOP.

ALU select codes: PASS_A = 000, ADD = 001, SUB = 010.

State transitions:
- INIT -> FETCH.
- FETCH -> DECODE. In FETCH, IR <= I_data and PC <= PC+1.
- DECODE -> NOOP / STORE / LOAD_A / ADD / SUB / HALT, selected by IR opcode.
- LOAD_A -> LOAD_B -> FETCH.
- NOOP, STORE, ADD, SUB -> FETCH.
- HALT -> HALT until reset.

Outputs are a combinational function of registered state and IR (Moore). Default for every output is 0. Per state:
- STORE: RF_Ra_addr = IR[11:8], D_Addr = IR[7:0], D_wr = 1.
- LOAD_A: D_Addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 0. This cycle covers the 1-cycle data memory read latency.
- LOAD_B: same D_Addr, RF_s and RF_W_addr as LOAD_A, plus RF_W_en = 1.
- ADD / SUB: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], RF_s = 0, RF_W_en = 1, Alu_s0 = ADD or SUB.
- HALT: halted = 1, PC and IR frozen.

PC rules:
- Increments only in FETCH.
- Wraps from 2^PC_W−1 to 0 with no special handling.

## Timing
- Reset: rst_n sampled low at a clk edge puts state = INIT and PC = 0, IR = 0 on that edge. All control outputs read 0 and halted = 0. This applies in any state, including mid-LOAD and HALT.
- Reset mid-LOAD: no RF write occurs if reset lands on LOAD_A.
- First FETCH is one cycle after rst_n is seen high. INIT lasts exactly one cycle, which covers the ROM latency for address 0.
- ROM latency: PC changes at the end of FETCH, and at least DECODE plus one execute state pass before the next FETCH. I_data is therefore always valid when sampled.
- Cycles per instruction, FETCH through the final execute state:
  - NOOP, STORE, ADD, SUB: 3.
  - LOAD: 4.
- Write-enable widths:
  - D_wr: high for exactly one cycle per STORE.
  - RF_W_en: high for exactly one cycle per LOAD, ADD or SUB.
  - Neither is ever high in INIT, FETCH, DECODE, NOOP or HALT.
- Writes commit in the datapath on the rising edge at the end of the asserting state.

## Structure
- Package cpu_pkg holds:
  - opcode enum (NOOP, STORE, LOAD, ADD, SUB, HALT);
  - state enum (INIT, FETCH, DECODE, NOOP_S, STORE_S, LOAD_A, LOAD_B, ADD_S, SUB_S, HALT_S), 4-bit;
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB;
  - instruction field bit positions.
- One sub-module, program_counter (inputs clr, up; output PC_W bits), instantiated in control_unit.
- The IR register and FSM stay in control_unit.

## Test plan
Benches use a 1-cycle-latency ROM model.
- **Reset:** hold rst_n low 2 cycles from mid-ADD -> PC = 0, IR = 0, state = INIT, D_wr = RF_W_en = 0 on the first low edge. Release rst_n -> FETCH on the next cycle.
- **LOAD:** ROM[0] = 16'h21B2 -> FETCH, DECODE, LOAD_A (D_Addr = 8'h1B, RF_s = 1, RF_W_addr = 2, RF_W_en = 0), LOAD_B (RF_W_en = 1), then FETCH. PC is 1 after FETCH.
- **ADD / SUB:** 16'h3123 -> in ADD_S: RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 3, Alu_s0 = 001, RF_s = 0, RF_W_en = 1 for exactly 1 cycle. 16'h4123 -> same with Alu_s0 = 010.
- **STORE:** 16'h122A -> RF_Ra_addr = 2, D_Addr = 8'h2A, D_wr = 1 for exactly 1 cycle; RF_W_en stays 0.
- **HALT:** 16'h5000 -> halted = 1, PC frozen, no D_wr or RF_W_en for 20 cycles. Then rst_n low -> INIT, halted = 0.
- **Undefined opcode / PC wrap:** 16'hF123 -> NOOP path with no writes. Preload PC = 127 (ROM full of NOOPs) -> after FETCH, PC = 0.
